// File: rtl/imm_decode_stage.sv
// Registered RV32I/RV64I immediate-decode stage.
// Extracts and sign-extends the immediate, classifies its format and flags
// unrecognised opcodes. A main register plus a one-entry skid register give
// full throughput while keeping in_ready free of any out_ready dependence.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_instr,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_INV = 3'd7;

  // OP-IMM-32 (ADDIW etc.) only exists on RV64
  localparam logic IS_RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t      dec;
  entry_t      main_q;
  entry_t      skid_q;
  logic        main_vld;
  logic        skid_vld;
  logic        accept;
  logic        main_free;
  logic [2:0]  fmt;
  logic [31:0] imm32;

  // Classify the incoming instruction by opcode
  always_comb begin
    fmt = FMT_INV;
    if (in_instr[1:0] == 2'b11) begin
      unique case (in_instr[6:0])
        7'b0110011: fmt = FMT_R;
        7'b0010011,
        7'b0000011,
        7'b1100111,
        7'b0001111: fmt = FMT_I;
        7'b0100011: fmt = FMT_S;
        7'b1100011: fmt = FMT_B;
        7'b0110111,
        7'b0010111: fmt = FMT_U;
        7'b1101111: fmt = FMT_J;
        7'b1110011: fmt = in_instr[14] ? FMT_Z : FMT_I;
        7'b0011011: fmt = IS_RV64 ? FMT_I : FMT_INV;
        default:    fmt = FMT_INV;
      endcase
    end
  end

  // Assemble the 32-bit immediate for the chosen format; widened below by
  // sign extension (Z has bit 31 clear, so it zero-extends naturally)
  always_comb begin
    imm32 = '0;
    unique case (fmt)
      FMT_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   imm32 = {in_instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      FMT_Z:   imm32 = {27'b0, in_instr[19:15]};
      default: imm32 = '0;
    endcase
  end

  // Pack the decoded entry that will be written into main or skid
  always_comb begin
    dec         = '0;
    dec.imm     = XLEN'($signed(imm32));
    dec.fmt     = fmt;
    dec.illegal = (fmt == FMT_INV);
    dec.instr   = in_instr;
    dec.tag     = in_tag;
  end

  // Skid occupancy alone gates input, so out_ready never reaches in_ready
  assign in_ready  = !rst && !skid_vld;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_vld || out_ready;

  // Main/skid update: skid drains first to preserve order; a stalled main
  // diverts the accepted entry into skid
  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (main_free) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        main_q   <= dec;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end

  assign out_valid   = main_vld;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_instr   = main_q.instr;
  assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed-vector and handshake bench for imm_decode_stage. An RV32 and an
// RV64 instance share the same input stream and handshake.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_instr32, out_tag32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_instr64, out_tag64;
  logic [2:0]  out_fmt64;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_illegal32), .out_instr(out_instr32), .out_tag(out_tag32)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64), .out_instr(out_instr64), .out_tag(out_tag64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // In-order scoreboard of instr/tag, fed and drained at the negedge
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] tag;
  } sb_t;
  sb_t sbq[$];
  sb_t exp_e;

  // Watch both handshakes; every transfer must match the oldest accepted entry
  always @(negedge clk) begin
    if (!rst) begin
      chk("hs_out_valid_64v32", {63'b0, out_valid64}, {63'b0, out_valid32});
      chk("hs_in_ready_64v32", {63'b0, in_ready64}, {63'b0, in_ready32});
      if (out_valid32 && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: output tag %h with nothing outstanding", out_tag32);
        end else begin
          exp_e = sbq.pop_front();
          chk("sb_tag32", {32'b0, out_tag32}, {32'b0, exp_e.tag});
          chk("sb_instr32", {32'b0, out_instr32}, {32'b0, exp_e.instr});
          chk("sb_tag64", {32'b0, out_tag64}, {32'b0, exp_e.tag});
          chk("sb_instr64", {32'b0, out_instr64}, {32'b0, exp_e.instr});
        end
      end
      if (in_valid && in_ready32) sbq.push_back('{instr: in_instr, tag: in_tag});
    end
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  localparam int NV = 17;
  vec_t vt[NV];

  initial begin
    int sent;
    int cyc;
    logic acc;

    // instr, imm32, fmt32, ill32, imm64, fmt64, ill64
    vt[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}; // ADDI -1
    vt[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0}; // SW -4
    vt[2]  = '{32'h001000EF, 32'h00000800, 3'd5, 1'b0, 64'h0000000000000800, 3'd5, 1'b0}; // JAL
    vt[3]  = '{32'hFE000FE3, 32'hFFFFFFFE, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFE, 3'd3, 1'b0}; // BEQ -2
    vt[4]  = '{32'h0002D073, 32'h00000005, 3'd6, 1'b0, 64'h0000000000000005, 3'd6, 1'b0}; // CSRRWI
    vt[5]  = '{32'h800002B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0}; // LUI
    vt[6]  = '{32'hFFF0009B, 32'h00000000, 3'd7, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}; // ADDIW
    vt[7]  = '{32'h00000000, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd7, 1'b1}; // zero word
    vt[8]  = '{32'h0000001B, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd1, 1'b0}; // OP-IMM-32
    vt[9]  = '{32'h00B50533, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0}; // ADD
    vt[10] = '{32'h12345117, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0}; // AUIPC
    vt[11] = '{32'h34011073, 32'h00000340, 3'd1, 1'b0, 64'h0000000000000340, 3'd1, 1'b0}; // CSRRW
    vt[12] = '{32'h80012083, 32'hFFFFF800, 3'd1, 1'b0, 64'hFFFFFFFFFFFFF800, 3'd1, 1'b0}; // LW -2048
    vt[13] = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd7, 1'b1}; // bad opcode
    vt[14] = '{32'h0FF0000F, 32'h000000FF, 3'd1, 1'b0, 64'h00000000000000FF, 3'd1, 1'b0}; // FENCE
    vt[15] = '{32'hFFC080E7, 32'hFFFFFFFC, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0}; // JALR -4
    vt[16] = '{32'h00000091, 32'h00000000, 3'd7, 1'b1, 64'h0000000000000000, 3'd7, 1'b1}; // low bits 01

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready32}, 64'd0);
    chk("rst_out_imm32", {32'b0, out_imm32}, 64'd0);
    chk("rst_out_imm64", out_imm64, 64'd0);
    chk("rst_out_fmt", {61'b0, out_fmt32}, 64'd0);
    chk("rst_out_illegal", {63'b0, out_illegal32}, 64'd0);
    chk("rst_out_instr", {32'b0, out_instr32}, 64'd0);
    chk("rst_out_tag", {32'b0, out_tag32}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", {63'b0, in_ready32}, 64'd1);

    // Directed decode vectors, back to back with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = vt[i].instr;
      in_tag   = 32'h100 + i;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), {63'b0, out_valid32}, 64'd1);
      chk($sformatf("vec%0d_imm32", i), {32'b0, out_imm32}, {32'b0, vt[i].imm32});
      chk($sformatf("vec%0d_fmt32", i), {61'b0, out_fmt32}, {61'b0, vt[i].fmt32});
      chk($sformatf("vec%0d_ill32", i), {63'b0, out_illegal32}, {63'b0, vt[i].ill32});
      chk($sformatf("vec%0d_imm64", i), out_imm64, vt[i].imm64);
      chk($sformatf("vec%0d_fmt64", i), {61'b0, out_fmt64}, {61'b0, vt[i].fmt64});
      chk($sformatf("vec%0d_ill64", i), {63'b0, out_illegal64}, {63'b0, vt[i].ill64});
      chk($sformatf("vec%0d_instr", i), {32'b0, out_instr32}, {32'b0, vt[i].instr});
      chk($sformatf("vec%0d_tag", i), {32'b0, out_tag32}, {32'b0, 32'h100 + i});
    end
    @(posedge clk);
    #1;
    chk("vec_drained", {63'b0, out_valid32}, 64'd0);

    // Stall: three tags offered while out_ready low for 4 cycles
    out_ready = 1'b0;
    in_valid  = 1'b1; in_instr = 32'h00100093; in_tag = 32'd1;
    chk("stall_in_ready0", {63'b0, in_ready32}, 64'd1);
    @(posedge clk); #1;
    in_instr = 32'h00200093; in_tag = 32'd2;
    chk("stall_in_ready1", {63'b0, in_ready32}, 64'd1);
    @(posedge clk); #1;
    in_instr = 32'h00300093; in_tag = 32'd3;
    chk("stall_in_ready_full", {63'b0, in_ready32}, 64'd0);
    chk("stall_tag1_head", {32'b0, out_tag32}, 64'd1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_hold_valid%0d", k), {63'b0, out_valid32}, 64'd1);
      chk($sformatf("stall_hold_tag%0d", k), {32'b0, out_tag32}, 64'd1);
      chk($sformatf("stall_hold_imm%0d", k), {32'b0, out_imm32}, 64'd1);
      chk($sformatf("stall_hold_ready%0d", k), {63'b0, in_ready32}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_tag2", {32'b0, out_tag32}, 64'd2);
    chk("release_in_ready", {63'b0, in_ready32}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release_tag3", {32'b0, out_tag32}, 64'd3);
    chk("release_imm3", {32'b0, out_imm32}, 64'd3);
    @(posedge clk); #1;
    chk("release_empty", {63'b0, out_valid32}, 64'd0);

    // Reset with both main and skid full
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00A00093; in_tag = 32'hAA;
    @(posedge clk); #1;
    in_instr = 32'h00B00093; in_tag = 32'hBB;
    @(posedge clk); #1;
    chk("prerst_full", {63'b0, in_ready32}, 64'd0);
    rst = 1'b1; in_valid = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    chk("midrst_out_valid32", {63'b0, out_valid32}, 64'd0);
    chk("midrst_out_valid64", {63'b0, out_valid64}, 64'd0);
    chk("midrst_in_ready", {63'b0, in_ready32}, 64'd0);
    chk("midrst_out_tag", {32'b0, out_tag32}, 64'd0);
    rst = 1'b0;
    #1;
    chk("postrst_in_ready", {63'b0, in_ready32}, 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("postrst_no_stale%0d", k), {63'b0, out_valid32}, 64'd0);
    end
    in_valid = 1'b1; in_instr = 32'h00C00093; in_tag = 32'hCC;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("postrst_new_tag", {32'b0, out_tag32}, 64'hCC);
    @(posedge clk); #1;

    // Random valid/ready traffic against the scoreboard
    sent = 0; cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = $urandom;
      in_tag    = 32'h1000_0000 + sent;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready32;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (sbq.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_sent", sent, 10000);
    chk("rand_drained", sbq.size(), 0);
    chk("rand_out_idle", {63'b0, out_valid32}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
